// File: rtl/hazard_sequencer_if.sv
// ============================================================================
//  Module      : hazard_sequencer_if
//  Description : Status/control bundle between the datapath/control unit
//                (master) and the hazard sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    // Register-match and stage-status inputs to the sequencer
    logic             Match_1E_M;
    logic             Match_1E_W;
    logic             Match_2E_M;
    logic             Match_2E_W;
    logic             Match_12D_E;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             BranchTakenE;
    logic             PCWrPendingF;
    logic             PCSrcW;
    logic             LongE;

    // Stall, flush and forward-select lines back to the datapath
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             LongStartE;
    logic             LongBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
        output PCWrPendingF, PCSrcW, LongE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, LongStartE, LongBusy, StallCount
    );

    modport slave (
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
        input  PCWrPendingF, PCSrcW, LongE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, LongStartE, LongBusy, StallCount
    );
endinterface

`default_nettype wire

// File: rtl/hazard_sequencer.sv
// ============================================================================
//  Module      : hazard_sequencer
//  Description : Five-stage pipeline hazard unit: operand forwarding,
//                load-use stall, PC-write/branch flush and a multi-cycle
//                Execute sequencer that holds the pipe for long ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sequencer #(
    parameter int MUL_CYCLES = 3,   // Execute occupancy of a long op, 2..15
    parameter int CNT_W      = 32   // stall performance counter width
) (
    input  wire logic          clk,
    input  wire logic          reset,   // asynchronous, active-low
    hazard_sequencer_if.slave  hz
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       c_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q;

    logic             w_exec_stall;
    logic             w_long_start;
    logic             w_ld_stall;
    logic             w_stall_f;

    // Long-op sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Long-op next state: a branch taken in Execute kills the long op before it starts
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_exec_stall = 1'b0;
        w_long_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.LongE && !hz.BranchTakenE) begin
                    w_exec_stall = 1'b1;
                    w_long_start = 1'b1;
                    state_d      = BUSY;
                    cnt_d        = 4'd1;
                end
            end
            BUSY: begin
                if (cnt_q < c_LAST) begin
                    w_exec_stall = 1'b1;
                    cnt_d        = cnt_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Forward/stall/flush decode; everything is held at zero while in reset
    always_comb begin
        hz.ForwardAE  = 2'b00;
        hz.ForwardBE  = 2'b00;
        hz.StallF     = 1'b0;
        hz.StallD     = 1'b0;
        hz.StallE     = 1'b0;
        hz.FlushD     = 1'b0;
        hz.FlushE     = 1'b0;
        hz.FlushM     = 1'b0;
        hz.LongStartE = 1'b0;
        w_ld_stall    = hz.Match_12D_E & hz.MemtoRegE;
        if (reset) begin
            // Memory-stage result is newer, so it beats Writeback
            if (hz.Match_1E_M && hz.RegWriteM)      hz.ForwardAE = 2'b10;
            else if (hz.Match_1E_W && hz.RegWriteW) hz.ForwardAE = 2'b01;
            if (hz.Match_2E_M && hz.RegWriteM)      hz.ForwardBE = 2'b10;
            else if (hz.Match_2E_W && hz.RegWriteW) hz.ForwardBE = 2'b01;

            hz.LongStartE = w_long_start;
            if (w_exec_stall) begin
                // Freeze F/D/E and bubble Memory; never flush the long op
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.FlushM = 1'b1;
            end else begin
                hz.StallF = w_ld_stall | hz.PCWrPendingF;
                hz.StallD = w_ld_stall;
                hz.FlushD = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
                hz.FlushE = w_ld_stall | hz.BranchTakenE;
            end
        end
    end

    assign w_stall_f   = hz.StallF;
    assign hz.LongBusy = reset & (state_q == BUSY);

    // Stall performance counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else if (w_stall_f) begin
            stall_count_q <= stall_count_q + c_ONE;
        end
    end

    assign hz.StallCount = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// ============================================================================
//  Module      : tb_hazard_sequencer
//  Description : Self-checking bench for hazard_sequencer: directed scenarios
//                with literal expectations plus randomized traffic compared
//                every cycle against an occupancy-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_sequencer;

    localparam int M  = 3;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model state: phase of the long op occupying Execute (-1 = none),
    // and the expected stall counter value.
    int   phase  = -1;
    int   scount = 0;
    logic e_start = 1'b0;
    logic e_sf    = 1'b0;

    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(CW)) bus ();

    hazard_sequencer #(.MUL_CYCLES(M), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.Match_1E_M   = 1'b0; bus.Match_1E_W = 1'b0;
        bus.Match_2E_M   = 1'b0; bus.Match_2E_W = 1'b0;
        bus.Match_12D_E  = 1'b0; bus.RegWriteM  = 1'b0;
        bus.RegWriteW    = 1'b0; bus.MemtoRegE  = 1'b0;
        bus.BranchTakenE = 1'b0; bus.PCWrPendingF = 1'b0;
        bus.PCSrcW       = 1'b0; bus.LongE      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Reset abandons any in-flight op and zeroes the counter at once
    always @(negedge reset) begin
        phase  = -1;
        scount = 0;
    end

    // Reference model compare: outputs from the hazard rules, every cycle
    always @(negedge clk) begin : cmp
        logic [1:0] fa, fb;
        logic es, ld, st, busy;
        logic sf, sd, se, fd, fe, fm;
        fa = 2'b00; fb = 2'b00; es = 1'b0; ld = 1'b0; st = 1'b0; busy = 1'b0;
        sf = 1'b0; sd = 1'b0; se = 1'b0; fd = 1'b0; fe = 1'b0; fm = 1'b0;
        if (reset) begin
            fa = (bus.Match_1E_M & bus.RegWriteM) ? 2'b10 :
                 (bus.Match_1E_W & bus.RegWriteW) ? 2'b01 : 2'b00;
            fb = (bus.Match_2E_M & bus.RegWriteM) ? 2'b10 :
                 (bus.Match_2E_W & bus.RegWriteW) ? 2'b01 : 2'b00;
            if (phase >= 0) begin
                busy = 1'b1;
                es   = (phase < M - 1);
            end else begin
                st = bus.LongE & ~bus.BranchTakenE;
                es = st;
            end
            if (es) begin
                sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1;
            end else begin
                ld = bus.Match_12D_E & bus.MemtoRegE;
                sf = ld | bus.PCWrPendingF;
                sd = ld;
                fd = bus.PCWrPendingF | bus.PCSrcW | bus.BranchTakenE;
                fe = ld | bus.BranchTakenE;
            end
        end
        e_start = st;
        e_sf    = sf;
        chk("ForwardAE",  32'(bus.ForwardAE),  32'(fa));
        chk("ForwardBE",  32'(bus.ForwardBE),  32'(fb));
        chk("StallF",     32'(bus.StallF),     32'(sf));
        chk("StallD",     32'(bus.StallD),     32'(sd));
        chk("StallE",     32'(bus.StallE),     32'(se));
        chk("FlushD",     32'(bus.FlushD),     32'(fd));
        chk("FlushE",     32'(bus.FlushE),     32'(fe));
        chk("FlushM",     32'(bus.FlushM),     32'(fm));
        chk("LongStartE", 32'(bus.LongStartE), 32'(st));
        chk("LongBusy",   32'(bus.LongBusy),   32'(busy));
        chk("StallCount", 32'(bus.StallCount), 32'(scount));
    end

    // Model advance on each clock edge out of reset
    always @(posedge clk) begin
        if (reset) begin
            if (phase >= 0) begin
                phase = phase + 1;
                if (phase >= M) phase = -1;
            end else if (e_start) begin
                phase = 1;
            end
            scount = (scount + int'(e_sf)) % (1 << CW);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        // Reset: outputs forced low even with active hazard inputs
        bus.Match_1E_M = 1'b1; bus.RegWriteM = 1'b1; bus.LongE = 1'b1;
        bus.MemtoRegE  = 1'b1; bus.Match_12D_E = 1'b1;
        settle();
        chk("rst_ForwardAE",  32'(bus.ForwardAE),  32'd0);
        chk("rst_LongStartE", 32'(bus.LongStartE), 32'd0);
        chk("rst_StallF",     32'(bus.StallF),     32'd0);
        chk("rst_StallCount", 32'(bus.StallCount), 32'd0);

        // Forward priority
        tick(); reset = 1'b1; clear_inputs();
        bus.Match_1E_M = 1'b1; bus.Match_1E_W = 1'b1;
        bus.RegWriteM  = 1'b1; bus.RegWriteW  = 1'b1;
        settle(); chk("fwd_mem_prio", 32'(bus.ForwardAE), 32'd2);
        tick(); bus.RegWriteM = 1'b0;
        settle(); chk("fwd_wb", 32'(bus.ForwardAE), 32'd1);
        tick(); bus.RegWriteW = 1'b0;
        settle(); chk("fwd_rf", 32'(bus.ForwardAE), 32'd0);

        // Load-use
        tick(); clear_inputs(); bus.MemtoRegE = 1'b1; bus.Match_12D_E = 1'b1;
        settle();
        chk("lu_StallF", 32'(bus.StallF), 32'd1);
        chk("lu_StallD", 32'(bus.StallD), 32'd1);
        chk("lu_FlushE", 32'(bus.FlushE), 32'd1);
        chk("lu_FlushD", 32'(bus.FlushD), 32'd0);
        tick(); clear_inputs();
        settle(); chk("lu_count", 32'(bus.StallCount), 32'd1);

        // Long op with LongE held high, then back-to-back restart
        tick(); bus.LongE = 1'b1;
        settle();
        chk("l0_start", 32'(bus.LongStartE), 32'd1);
        chk("l0_StallE", 32'(bus.StallE), 32'd1);
        chk("l0_FlushM", 32'(bus.FlushM), 32'd1);
        tick(); settle();
        chk("l1_busy", 32'(bus.LongBusy), 32'd1);
        chk("l1_StallE", 32'(bus.StallE), 32'd1);
        chk("l1_start", 32'(bus.LongStartE), 32'd0);
        tick(); settle();
        chk("l2_StallE", 32'(bus.StallE), 32'd0);
        chk("l2_FlushM", 32'(bus.FlushM), 32'd0);
        chk("l2_count", 32'(bus.StallCount), 32'd3);
        tick(); settle();
        chk("l3_busy", 32'(bus.LongBusy), 32'd0);
        chk("l3_restart", 32'(bus.LongStartE), 32'd1);
        tick(); bus.LongE = 1'b0;
        tick(); tick(); settle();
        chk("l_idle_busy", 32'(bus.LongBusy), 32'd0);
        chk("l_idle_count", 32'(bus.StallCount), 32'd5);

        // Long op with concurrent load-use and pending PC write
        tick(); bus.LongE = 1'b1; bus.MemtoRegE = 1'b1;
        bus.Match_12D_E = 1'b1; bus.PCWrPendingF = 1'b1;
        settle();
        chk("lh0_FlushE", 32'(bus.FlushE), 32'd0);
        chk("lh0_FlushD", 32'(bus.FlushD), 32'd0);
        tick(); settle();
        chk("lh1_FlushE", 32'(bus.FlushE), 32'd0);
        chk("lh1_FlushD", 32'(bus.FlushD), 32'd0);
        tick(); settle();
        chk("lh2_StallF", 32'(bus.StallF), 32'd1);
        chk("lh2_FlushD", 32'(bus.FlushD), 32'd1);
        chk("lh2_FlushE", 32'(bus.FlushE), 32'd1);
        chk("lh2_StallE", 32'(bus.StallE), 32'd0);
        tick(); clear_inputs();
        settle(); chk("lh_count", 32'(bus.StallCount), 32'd8);

        // Branch beats a long op in IDLE
        tick(); bus.LongE = 1'b1; bus.BranchTakenE = 1'b1;
        settle();
        chk("br_start", 32'(bus.LongStartE), 32'd0);
        chk("br_FlushD", 32'(bus.FlushD), 32'd1);
        chk("br_FlushE", 32'(bus.FlushE), 32'd1);
        tick(); clear_inputs();
        settle(); chk("br_busy", 32'(bus.LongBusy), 32'd0);

        // Reset while BUSY with cnt=1
        tick(); bus.LongE = 1'b1;
        tick(); bus.LongE = 1'b0;
        settle(); chk("rm_busy_pre", 32'(bus.LongBusy), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rm_busy",  32'(bus.LongBusy),   32'd0);
        chk("rm_StallE", 32'(bus.StallE),    32'd0);
        chk("rm_count", 32'(bus.StallCount), 32'd0);
        tick(); reset = 1'b1;
        settle();
        chk("rm_after_busy",  32'(bus.LongBusy), 32'd0);
        chk("rm_after_StallE", 32'(bus.StallE),  32'd0);

        // Randomized traffic, including rare resets and counter wrap
        for (int i = 0; i < 1500; i++) begin
            tick();
            reset             = ($urandom_range(149) != 0);
            bus.Match_1E_M    = 1'($urandom_range(1));
            bus.Match_1E_W    = 1'($urandom_range(1));
            bus.Match_2E_M    = 1'($urandom_range(1));
            bus.Match_2E_W    = 1'($urandom_range(1));
            bus.Match_12D_E   = 1'($urandom_range(1));
            bus.RegWriteM     = 1'($urandom_range(1));
            bus.RegWriteW     = 1'($urandom_range(1));
            bus.MemtoRegE     = ($urandom_range(2) == 0);
            bus.BranchTakenE  = ($urandom_range(7) == 0);
            bus.PCWrPendingF  = ($urandom_range(7) == 0);
            bus.PCSrcW        = ($urandom_range(7) == 0);
            bus.LongE         = ($urandom_range(3) == 0);
        end
        tick(); reset = 1'b1; clear_inputs();
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
